vert16_col_scheduler: RTL and testbench

- Sequencer for one 16-lane vertical bit-column MAC (the Vert_16 MAC datapath).
- Accepts a job header: column count and accumulator-preload flag.
- Streams per-column descriptors into the MAC, one per enabled cycle, LSB column first.
- Generates column_idx, is_msb, load_accum and en, issues the extra flush cycle the MAC's registered partial-sum stage needs, and flags when the MAC result is final.

---
 rtl/vert16_pkg.sv | 34 +++
 rtl/vert16_col_scheduler.sv | 155 +++++++++++++++
 tb/tb_vert16_col_scheduler.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vert16_pkg.sv
// Shared types and constants for the Vert_16 bit-column MAC scheduler.
package vert16_pkg;

  localparam int VEC_LENGTH = 16;
  localparam int SEL_WIDTH  = $clog2(VEC_LENGTH) - 1;
  localparam int MAX_COL    = 8;
  localparam int COL_W      = $clog2(MAX_COL);

  typedef struct packed {
    logic [SEL_WIDTH*VEC_LENGTH/2-1:0] act_sel;
    logic [VEC_LENGTH/2-1:0]           act_val;
    logic [VEC_LENGTH/8-1:0]           skip_zero;
    logic [2:0]                        mul_const;
    logic                              shift_mul;
    logic                              en_mul;
    logic                              zero;
  } col_desc_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } sched_state_t;

  // Descriptor that makes the MAC add nothing: no lanes valid, every group skipped.
  function automatic col_desc_t idle_desc();
    col_desc_t d;
    d           = '0;
    d.skip_zero = '1;
    return d;
  endfunction

endpackage

// File: rtl/vert16_col_scheduler.sv
// Column sequencer for the 16-lane vertical bit-column MAC: job header in, one descriptor per MAC cycle out.
// Optional macro VERT16_ZERO_COL_SKIP_EN: all-zero columns are consumed without spending a MAC cycle.
module vert16_col_scheduler #(
  parameter int VEC_LENGTH = 16,
  parameter int SEL_WIDTH  = $clog2(VEC_LENGTH) - 1,
  parameter int MAX_COL    = 8
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_job_valid,
  output logic                              o_job_ready,
  input  logic [2:0]                        i_job_ncol_m1,
  input  logic                              i_job_load_prev,
  input  logic                              i_col_valid,
  output logic                              o_col_ready,
  input  logic [SEL_WIDTH*VEC_LENGTH/2-1:0] i_col_act_sel,
  input  logic [VEC_LENGTH/2-1:0]           i_col_act_val,
  input  logic [VEC_LENGTH/8-1:0]           i_col_skip_zero,
  input  logic [2:0]                        i_col_mul_const,
  input  logic                              i_col_shift_mul,
  input  logic                              i_col_en_mul,
  input  logic                              i_col_zero,
  output logic                              o_mac_en,
  output logic                              o_mac_load_accum,
  output logic [2:0]                        o_mac_column_idx,
  output logic                              o_mac_is_msb,
  output logic [SEL_WIDTH*VEC_LENGTH/2-1:0] o_mac_act_sel,
  output logic [VEC_LENGTH/2-1:0]           o_mac_act_val,
  output logic [VEC_LENGTH/8-1:0]           o_mac_skip_zero,
  output logic [2:0]                        o_mac_mul_const,
  output logic                              o_mac_shift_mul,
  output logic                              o_mac_en_mul,
  output logic                              o_res_valid,
  output logic                              o_busy
);

  import vert16_pkg::*;

  sched_state_t r_state;
  logic [2:0]   r_col_idx;
  logic [2:0]   r_ncol_m1;
  logic         r_load_pending;

  logic         w_hs;
  logic         w_zero_col;
  logic         w_issue;
  logic         w_last;
  col_desc_t    w_in_desc;
  col_desc_t    w_out_desc;

  assign w_in_desc = '{act_sel:   i_col_act_sel,
                       act_val:   i_col_act_val,
                       skip_zero: i_col_skip_zero,
                       mul_const: i_col_mul_const,
                       shift_mul: i_col_shift_mul,
                       en_mul:    i_col_en_mul,
                       zero:      i_col_zero};

`ifdef VERT16_ZERO_COL_SKIP_EN
  assign w_zero_col = i_col_zero;
`else
  logic w_unused_col_zero;
  assign w_zero_col        = 1'b0;
  assign w_unused_col_zero = w_in_desc.zero;
`endif

  assign w_hs    = (r_state == RUN) && i_col_valid;
  assign w_issue = w_hs && !w_zero_col;
  assign w_last  = (r_col_idx == r_ncol_m1);

  // The pending-load flag survives skipped columns so the first real MAC cycle (or FLUSH) loads accum_prev.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= IDLE;
      r_col_idx      <= '0;
      r_ncol_m1      <= '0;
      r_load_pending <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_job_valid) begin
            r_ncol_m1      <= i_job_ncol_m1;
            r_load_pending <= i_job_load_prev;
            r_col_idx      <= '0;
            r_state        <= RUN;
          end
        end
        RUN: begin
          if (w_hs) begin
            r_col_idx <= r_col_idx + 3'd1;
            if (w_issue) r_load_pending <= 1'b0;
            if (w_last)  r_state        <= FLUSH;
          end
        end
        FLUSH: begin
          r_load_pending <= 1'b0;
          r_state        <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs are combinational so mac_en lines up with the descriptor handshake; reset forces the idle values.
  always_comb begin
    o_job_ready      = 1'b0;
    o_col_ready      = 1'b0;
    o_mac_en         = 1'b0;
    o_mac_load_accum = 1'b0;
    o_mac_column_idx = '0;
    o_mac_is_msb     = 1'b0;
    o_res_valid      = 1'b0;
    o_busy           = 1'b0;
    w_out_desc       = idle_desc();
    if (!i_reset) begin
      case (r_state)
        IDLE: begin
          o_job_ready = 1'b1;
        end
        RUN: begin
          o_busy      = 1'b1;
          o_col_ready = i_col_valid;
          if (w_issue) begin
            o_mac_en         = 1'b1;
            o_mac_load_accum = r_load_pending;
            o_mac_column_idx = r_col_idx;
            o_mac_is_msb     = w_last;
            w_out_desc       = w_in_desc;
          end
        end
        FLUSH: begin
          o_busy           = 1'b1;
          o_mac_en         = 1'b1;
          o_mac_load_accum = r_load_pending;
        end
        DONE: begin
          o_busy      = 1'b1;
          o_res_valid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_mac_act_sel   = w_out_desc.act_sel;
  assign o_mac_act_val   = w_out_desc.act_val;
  assign o_mac_skip_zero = w_out_desc.skip_zero;
  assign o_mac_mul_const = w_out_desc.mul_const;
  assign o_mac_shift_mul = w_out_desc.shift_mul;
  assign o_mac_en_mul    = w_out_desc.en_mul;

endmodule

// File: tb/tb_vert16_col_scheduler.sv
// Scoreboard bench for vert16_col_scheduler; expectations follow VERT16_ZERO_COL_SKIP_EN when defined.
module tb_vert16_col_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        job_valid, job_ready, job_load_prev;
  logic [2:0]  job_ncol_m1;
  logic        col_valid, col_ready;
  logic [23:0] col_act_sel;
  logic [7:0]  col_act_val;
  logic [1:0]  col_skip_zero;
  logic [2:0]  col_mul_const;
  logic        col_shift_mul, col_en_mul, col_zero;
  logic        mac_en, mac_load_accum, mac_is_msb;
  logic [2:0]  mac_column_idx;
  logic [23:0] mac_act_sel;
  logic [7:0]  mac_act_val;
  logic [1:0]  mac_skip_zero;
  logic [2:0]  mac_mul_const;
  logic        mac_shift_mul, mac_en_mul;
  logic        res_valid, busy;

  typedef struct {
    logic [2:0]  idx;
    logic        msb;
    logic        load;
    logic [23:0] sel;
    logic [7:0]  val;
    logic [1:0]  skip;
    logic [2:0]  mc;
    logic        sh;
    logic        em;
    logic        flush;
  } exp_t;

  exp_t       expQ[$];
  int         resQ[$];
  exp_t       monE;
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         resCount = 0;
  int         jobT = 0;
  int         lastRes = 0;
  int         bubCount = 0;
  logic [2:0] curN;
  logic       loadPending;
  bit         keepJob = 1'b0;

  vert16_col_scheduler dut (
    .i_clk(clk), .i_reset(reset),
    .i_job_valid(job_valid), .o_job_ready(job_ready),
    .i_job_ncol_m1(job_ncol_m1), .i_job_load_prev(job_load_prev),
    .i_col_valid(col_valid), .o_col_ready(col_ready),
    .i_col_act_sel(col_act_sel), .i_col_act_val(col_act_val),
    .i_col_skip_zero(col_skip_zero), .i_col_mul_const(col_mul_const),
    .i_col_shift_mul(col_shift_mul), .i_col_en_mul(col_en_mul),
    .i_col_zero(col_zero),
    .o_mac_en(mac_en), .o_mac_load_accum(mac_load_accum),
    .o_mac_column_idx(mac_column_idx), .o_mac_is_msb(mac_is_msb),
    .o_mac_act_sel(mac_act_sel), .o_mac_act_val(mac_act_val),
    .o_mac_skip_zero(mac_skip_zero), .o_mac_mul_const(mac_mul_const),
    .o_mac_shift_mul(mac_shift_mul), .o_mac_en_mul(mac_en_mul),
    .o_res_valid(res_valid), .o_busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, expv, cyc);
    end
  endtask

  // Every MAC cycle must match the next queued expectation; res_valid must land on its predicted cycle.
  always @(negedge clk) begin
    if (mac_en === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_mac_en", 1, 0);
      end else begin
        monE = expQ.pop_front();
        checkOutput("load_accum", mac_load_accum, monE.load);
        checkOutput("is_msb", mac_is_msb, monE.msb);
        checkOutput("act_val", mac_act_val, monE.val);
        checkOutput("skip_zero", mac_skip_zero, monE.skip);
        checkOutput("en_mul", mac_en_mul, monE.em);
        if (!monE.flush) begin
          checkOutput("column_idx", mac_column_idx, monE.idx);
          checkOutput("act_sel", mac_act_sel, monE.sel);
          checkOutput("mul_const", mac_mul_const, monE.mc);
          checkOutput("shift_mul", mac_shift_mul, monE.sh);
        end
      end
    end
    if (res_valid === 1'b1) begin
      resCount++;
      checkOutput("res_mac_en_low", mac_en, 0);
      if (resQ.size() == 0) checkOutput("spurious_res_valid", 1, 0);
      else checkOutput("res_cycle", cyc, resQ.pop_front());
    end
  end

  task automatic startJob(input logic [2:0] n, input logic lp, input bit keep, input bit chkImm);
    bit got = 1'b0;
    job_valid     = 1'b1;
    job_ncol_m1   = n;
    job_load_prev = lp;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (job_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checkOutput("job_accept", got, 1);
    jobT = cyc;
    if (chkImm) checkOutput("job_after_res", jobT, lastRes + 1);
    @(posedge clk); #1;
    job_valid   = keep;
    keepJob     = keep;
    curN        = n;
    loadPending = lp;
    bubCount    = 0;
  endtask

  task automatic driveCol(input int i, input bit zero);
    exp_t e;
    bit   effZero;
`ifdef VERT16_ZERO_COL_SKIP_EN
    effZero = zero;
`else
    effZero = 1'b0;
`endif
    col_valid     = 1'b1;
    col_zero      = zero;
    col_act_sel   = 24'($urandom);
    col_act_val   = 8'($urandom);
    col_skip_zero = 2'($urandom);
    col_mul_const = 3'($urandom);
    col_shift_mul = 1'($urandom);
    col_en_mul    = 1'($urandom);
    if (!effZero) begin
      e.idx   = 3'(i);
      e.msb   = (3'(i) == curN);
      e.load  = loadPending;
      e.sel   = col_act_sel;
      e.val   = col_act_val;
      e.skip  = col_skip_zero;
      e.mc    = col_mul_const;
      e.sh    = col_shift_mul;
      e.em    = col_en_mul;
      e.flush = 1'b0;
      expQ.push_back(e);
      loadPending = 1'b0;
    end else begin
      @(negedge clk);
      checkOutput("zero_col_no_en", mac_en, 0);
    end
    if (!effZero) @(negedge clk);
    checkOutput("col_ready", col_ready, 1);
    checkOutput("busy_run", busy, 1);
    if (keepJob) checkOutput("job_ready_held", job_ready, 0);
    @(posedge clk); #1;
    col_valid = 1'b0;
    col_zero  = 1'b0;
  endtask

  task automatic bubble();
    col_valid = 1'b0;
    @(negedge clk);
    checkOutput("bubble_mac_en", mac_en, 0);
    @(posedge clk); #1;
    bubCount++;
  endtask

  task automatic finishJob();
    exp_t e;
    int   startRes;
    bit   got = 1'b0;
    e       = '{idx: 3'd0, msb: 1'b0, load: loadPending, sel: 24'd0, val: 8'd0,
                skip: 2'b11, mc: 3'd0, sh: 1'b0, em: 1'b0, flush: 1'b1};
    expQ.push_back(e);
    resQ.push_back(jobT + int'(curN) + 3 + bubCount);
    startRes = resCount;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #1;
      if (resCount > startRes) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("res_seen", got, 1);
    lastRes = cyc;
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus(input logic [2:0] n, input logic lp, input bit keep, input bit chkImm,
                               input int bubAt, input int bubN, input logic [7:0] zeroMask);
    startJob(n, lp, keep, chkImm);
    for (int i = 0; i <= int'(n); i++) begin
      if (i == bubAt) repeat (bubN) bubble();
      driveCol(i, zeroMask[i]);
    end
    finishJob();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int savedRes;
    reset = 1'b1; job_valid = 1'b1; job_ncol_m1 = 3'd0; job_load_prev = 1'b0;
    col_valid = 1'b1; col_act_sel = '0; col_act_val = '0; col_skip_zero = '0;
    col_mul_const = '0; col_shift_mul = 1'b0; col_en_mul = 1'b0; col_zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_job_ready", job_ready, 0);
    checkOutput("rst_col_ready", col_ready, 0);
    checkOutput("rst_mac_en", mac_en, 0);
    checkOutput("rst_skip_zero", mac_skip_zero, 2'b11);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0; job_valid = 1'b0;
    @(negedge clk);
    checkOutput("idle_job_ready", job_ready, 1);
    checkOutput("idle_col_ready", col_ready, 0);
    checkOutput("idle_mac_en", mac_en, 0);
    @(posedge clk); #1;
    col_valid = 1'b0;

    applyStimulus(3'd7, 1'b1, 1'b0, 1'b0, 99, 0, 8'h00);
    applyStimulus(3'd0, 1'b0, 1'b0, 1'b0, 99, 0, 8'h00);
    applyStimulus(3'd3, 1'b0, 1'b0, 1'b0, 2, 2, 8'h00);

    startJob(3'd3, 1'b1, 1'b0, 1'b0);
    driveCol(0, 1'b0);
    driveCol(1, 1'b0);
    col_valid = 1'b1;
    reset     = 1'b1;
    @(negedge clk);
    checkOutput("midrst_mac_en", mac_en, 0);
    checkOutput("midrst_col_ready", col_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0; col_valid = 1'b0;
    @(negedge clk);
    savedRes = resCount;
    checkOutput("postrst_busy", busy, 0);
    checkOutput("postrst_mac_en", mac_en, 0);
    checkOutput("postrst_job_ready", job_ready, 1);
    checkOutput("postrst_skip_zero", mac_skip_zero, 2'b11);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("postrst_no_res", resCount, savedRes);
    applyStimulus(3'd1, 1'b1, 1'b0, 1'b0, 99, 0, 8'h00);

    applyStimulus(3'd2, 1'b1, 1'b1, 1'b0, 99, 0, 8'h00);
    applyStimulus(3'd1, 1'b0, 1'b0, 1'b1, 99, 0, 8'h00);

    applyStimulus(3'd3, 1'b1, 1'b0, 1'b0, 99, 0, 8'h01);
    applyStimulus(3'd1, 1'b1, 1'b0, 1'b0, 99, 0, 8'h03);
    applyStimulus(3'd2, 1'b0, 1'b0, 1'b0, 1, 1, 8'h04);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("exp_queue_drained", expQ.size(), 0);
    checkOutput("res_queue_drained", resQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
